// File: rtl/irq_pending_ctrl.sv
// Request-capture stage: latches raw request lines into a pending register and
// grants the highest-index enabled pending line through a valid/ack handshake.
module irq_pending_ctrl #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       clear_all,
  input  logic       irq_ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic       pend_any
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pending;
  logic [2:0] r_irq_id;
  logic [7:0] w_set_vec;
  logic [7:0] w_ack_clr;
  logic [7:0] w_cand;
  logic [2:0] w_top_idx;
  logic       w_ack_fire;
  logic       w_grant;

  // A line held high through reset still yields one event, since r_req_q starts at 0.
  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [7:0] r_req_q;

      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values and simulation ordering cannot change the result.
      always_ff @(posedge clk) begin
        if (rst) r_req_q <= '0;
        else     r_req_q <= req;
      end

      assign w_set_vec = req & ~r_req_q;
    end else begin : g_level
      assign w_set_vec = req;
    end
  endgenerate

  assign w_ack_fire = irq_valid & irq_ack;
  assign w_ack_clr  = w_ack_fire ? (8'b1 << r_irq_id) : 8'b0;
  assign w_cand     = r_pending & mask;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_top_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_cand[i]) w_top_idx = 3'(i);
    end
  end

  // Set wins over ack-clear on the same bit; clear_all discards same-cycle sets.
  always_ff @(posedge clk) begin
    if (rst)            r_pending <= '0;
    else if (clear_all) r_pending <= '0;
    else                r_pending <= (r_pending & ~w_ack_clr) | w_set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_cand != 8'h00 && !clear_all) w_state_nxt = S_PRESENT;
      S_PRESENT: if (clear_all || irq_ack)          w_state_nxt = S_IDLE;
      default:                                      w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant = (r_state == S_IDLE) && (w_state_nxt == S_PRESENT);

  // The id is captured only on entry to PRESENT, so mask or request changes
  // during a presentation cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst)          r_irq_id <= '0;
    else if (w_grant) r_irq_id <= w_top_idx;
  end

  always_comb begin
    irq_valid = (r_state == S_PRESENT);
    irq_id    = r_irq_id;
    pending   = r_pending;
    pend_any  = |r_pending;
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: one edge-mode and one level-mode instance
// share stimulus; each has its own ack so the consumer can be modelled per mode.
module tb_irq_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       clear_all;
  logic       ack_e;
  logic       ack_l;

  logic       v_e, v_l;
  logic [2:0] id_e, id_l;
  logic [7:0] pend_e, pend_l;
  logic       any_e, any_l;

  int tests = 0;
  int fails = 0;

  irq_pending_ctrl #(.EDGE_MODE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .clear_all(clear_all),
    .irq_ack(ack_e), .irq_valid(v_e), .irq_id(id_e), .pending(pend_e), .pend_any(any_e)
  );

  irq_pending_ctrl #(.EDGE_MODE(0)) dut_lvl (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .clear_all(clear_all),
    .irq_ack(ack_l), .irq_valid(v_l), .irq_id(id_l), .pending(pend_l), .pend_any(any_l)
  );

  always #5 clk = ~clk;

  // Packs {irq_valid, irq_id, pending, pend_any} into one comparable word.
  function automatic logic [12:0] pack(input logic v, input logic [2:0] id,
                                       input logic [7:0] p, input logic a);
    return {v, id, p, a};
  endfunction

  // Advance one rising edge; return on the following falling edge, where
  // outputs are sampled and new inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1; req = 8'h00; mask = 8'hFF; clear_all = 1'b0; ack_e = 1'b0; ack_l = 1'b0;
    step();
    obs = pack(v_e, id_e, pend_e, any_e);
    tests++;
    if (obs !== pack(1'b0, 3'd0, 8'h00, 1'b0)) begin
      fails++; $display("FAIL reset_state got=%h want=%h", obs, pack(1'b0, 3'd0, 8'h00, 1'b0));
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      obs = pack(v_e, id_e, pend_e, any_e);
      tests++;
      if (obs !== pack(1'b0, 3'd0, 8'h00, 1'b0)) begin
        fails++; $display("FAIL idle_after_reset[%0d] got=%h want=%h", i, obs, pack(1'b0, 3'd0, 8'h00, 1'b0));
      end
    end
  endtask

  task automatic test_two_pulse();
    logic [12:0] obs;
    req = 8'h24; step(); req = 8'h00;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd0, 8'h24, 1'b1)) begin
      fails++; $display("FAIL pulse_pending got=%h want=%h", obs, pack(1'b0, 3'd0, 8'h24, 1'b1));
    end
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd5, 8'h24, 1'b1)) begin
      fails++; $display("FAIL pulse_grant5 got=%h want=%h", obs, pack(1'b1, 3'd5, 8'h24, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd5, 8'h04, 1'b1)) begin
      fails++; $display("FAIL pulse_ack5_idle got=%h want=%h", obs, pack(1'b0, 3'd5, 8'h04, 1'b1));
    end
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd2, 8'h04, 1'b1)) begin
      fails++; $display("FAIL pulse_grant2 got=%h want=%h", obs, pack(1'b1, 3'd2, 8'h04, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd2, 8'h00, 1'b0)) begin
      fails++; $display("FAIL pulse_ack2 got=%h want=%h", obs, pack(1'b0, 3'd2, 8'h00, 1'b0));
    end
  endtask

  task automatic test_mask();
    logic [12:0] obs;
    mask = 8'h7F; req = 8'h82; step(); req = 8'h00;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd1, 8'h82, 1'b1)) begin
      fails++; $display("FAIL mask_grant1 got=%h want=%h", obs, pack(1'b1, 3'd1, 8'h82, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd1, 8'h80, 1'b1)) begin
      fails++; $display("FAIL mask_retained got=%h want=%h", obs, pack(1'b0, 3'd1, 8'h80, 1'b1));
    end
    mask = 8'hFF; step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd7, 8'h80, 1'b1)) begin
      fails++; $display("FAIL mask_grant7 got=%h want=%h", obs, pack(1'b1, 3'd7, 8'h80, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs;
    req = 8'h08; step(); req = 8'h00;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd3, 8'h08, 1'b1)) begin
      fails++; $display("FAIL b2b_grant3 got=%h want=%h", obs, pack(1'b1, 3'd3, 8'h08, 1'b1));
    end
    ack_e = 1'b1; req = 8'h08; step(); ack_e = 1'b0; req = 8'h00;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd3, 8'h08, 1'b1)) begin
      fails++; $display("FAIL b2b_set_wins got=%h want=%h", obs, pack(1'b0, 3'd3, 8'h08, 1'b1));
    end
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd3, 8'h08, 1'b1)) begin
      fails++; $display("FAIL b2b_regrant3 got=%h want=%h", obs, pack(1'b1, 3'd3, 8'h08, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd3, 8'h00, 1'b0)) begin
      fails++; $display("FAIL b2b_drained got=%h want=%h", obs, pack(1'b0, 3'd3, 8'h00, 1'b0));
    end
  endtask

  task automatic test_grant_hold();
    logic [12:0] obs;
    mask = 8'h00; req = 8'h01; step(); req = 8'h00;
    ack_e = 1'b1; step(); ack_e = 1'b0;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd3, 8'h01, 1'b1)) begin
      fails++; $display("FAIL ack_idle_ignored got=%h want=%h", obs, pack(1'b0, 3'd3, 8'h01, 1'b1));
    end
    mask = 8'hFF; step();
    mask = 8'hFE; req = 8'h80; step(); req = 8'h00;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd0, 8'h81, 1'b1)) begin
      fails++; $display("FAIL grant_held got=%h want=%h", obs, pack(1'b1, 3'd0, 8'h81, 1'b1));
    end
    ack_e = 1'b1; step(); ack_e = 1'b0;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd7, 8'h80, 1'b1)) begin
      fails++; $display("FAIL grant_after_hold got=%h want=%h", obs, pack(1'b1, 3'd7, 8'h80, 1'b1));
    end
    mask = 8'hFF; ack_e = 1'b1; step(); ack_e = 1'b0;
  endtask

  task automatic test_clear_all();
    logic [12:0] obs;
    req = 8'hF0; step(); req = 8'h00;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd7, 8'hF0, 1'b1)) begin
      fails++; $display("FAIL clr_pre got=%h want=%h", obs, pack(1'b1, 3'd7, 8'hF0, 1'b1));
    end
    clear_all = 1'b1; step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd7, 8'h00, 1'b0)) begin
      fails++; $display("FAIL clr_present got=%h want=%h", obs, pack(1'b0, 3'd7, 8'h00, 1'b0));
    end
    req = 8'h01; step(); clear_all = 1'b0; req = 8'h00;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd7, 8'h00, 1'b0)) begin
      fails++; $display("FAIL clr_discards_set got=%h want=%h", obs, pack(1'b0, 3'd7, 8'h00, 1'b0));
    end
  endtask

  task automatic test_rst_mid_grant();
    logic [12:0] obs;
    req = 8'h0C; step(); req = 8'h00;
    step();
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b1, 3'd3, 8'h0C, 1'b1)) begin
      fails++; $display("FAIL rst_pre got=%h want=%h", obs, pack(1'b1, 3'd3, 8'h0C, 1'b1));
    end
    rst = 1'b1; ack_e = 1'b1; req = 8'hFF; step(); ack_e = 1'b0; req = 8'h00; rst = 1'b0;
    obs = pack(v_e, id_e, pend_e, any_e); tests++;
    if (obs !== pack(1'b0, 3'd0, 8'h00, 1'b0)) begin
      fails++; $display("FAIL rst_mid_grant got=%h want=%h", obs, pack(1'b0, 3'd0, 8'h00, 1'b0));
    end
  endtask

  // Consumer acks on the second cycle it sees valid; req[0] is high for 20 edges.
  // Edge mode: a single grant. Level mode: grants at E1,E4,...,E19 -> 7.
  task automatic test_edge_vs_level();
    int vc_e = 0, vc_l = 0, g_e = 0, g_l = 0;
    logic pv_e = 1'b0, pv_l = 1'b0;
    rst = 1'b1; req = 8'h00; step(); rst = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      req = (cyc < 20) ? 8'h01 : 8'h00;
      if (v_e && !pv_e) g_e++;
      if (v_l && !pv_l) g_l++;
      pv_e = v_e; pv_l = v_l;
      vc_e = v_e ? vc_e + 1 : 0;
      vc_l = v_l ? vc_l + 1 : 0;
      ack_e = (vc_e == 2);
      ack_l = (vc_l == 2);
      step();
    end
    ack_e = 1'b0; ack_l = 1'b0;
    tests++;
    if (g_e !== 1) begin
      fails++; $display("FAIL edge_grant_count got=%0d want=1", g_e);
    end
    tests++;
    if (g_l !== 7) begin
      fails++; $display("FAIL level_grant_count got=%0d want=7", g_l);
    end
    tests++;
    if (pack(v_l, id_l, pend_l, any_l) !== pack(1'b0, 3'd0, 8'h00, 1'b0)) begin
      fails++; $display("FAIL level_drained got=%h want=%h", pack(v_l, id_l, pend_l, any_l), pack(1'b0, 3'd0, 8'h00, 1'b0));
    end
    tests++;
    if (pack(v_e, id_e, pend_e, any_e) !== pack(1'b0, 3'd0, 8'h00, 1'b0)) begin
      fails++; $display("FAIL edge_drained got=%h want=%h", pack(v_e, id_e, pend_e, any_e), pack(1'b0, 3'd0, 8'h00, 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_two_pulse();
    test_mask();
    test_back_to_back();
    test_grant_hold();
    test_clear_all();
    test_rst_mid_grant();
    test_edge_vs_level();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Upstream request-capture stage for the 8-to-3 priority encoder.
- Latches 8 raw request lines into a pending register and applies an enable mask.
- Presents the highest-index enabled pending request as a 3-bit id with a valid/ack handshake.
- Clears each pending bit when the consumer acknowledges it, so each event is serviced exactly once.

Parameters:
- EDGE_MODE, 1, 1 = pending bit set on a rising edge of req[i]; 0 = set on every cycle req[i] is high (level mode).

Ports:
- clk        input   1  system clock; all state updates on the rising edge
- rst        input   1  synchronous, active-high reset
- req        input   8  raw request lines; bit 7 is highest priority
- mask       input   8  per-line enable; 1 = line may be granted
- clear_all  input   1  synchronous discard of all pending requests and any grant in flight
- irq_ack    input   1  consumer accepts the presented id
- irq_valid  output  1  irq_id is valid and held stable
- irq_id     output  3  index of the granted request, 3'b000..3'b111
- pending    output  8  pending register, for status
- pend_any   output  1  OR-reduction of pending

Behaviour:
- Reset (rst=1 at a clock edge):
  - pending=0, req_q=0, state=IDLE, irq_valid=0, irq_id=0, pend_any=0.
  - rst overrides every other input.
- Event detect:
  - EDGE_MODE=1: set_vec = req & ~req_q; req_q <= req every cycle.
  - Because req_q resets to 0, a line held high through reset produces exactly one event on its first sample.
  - EDGE_MODE=0: set_vec = req.
- Pending update, each edge, in priority order:
  - clear_all=1: pending <= 0.
  - Otherwise: pending <= (pending & ~ack_clr) | set_vec, where ack_clr is a one-hot of irq_id, active only when irq_valid & irq_ack.
  - A set and an ack-clear on the same bit in the same cycle: the set wins, so the new event stays pending.
  - A set in the same cycle as clear_all is discarded.
- Candidates: cand = pending & mask. Masked pending bits are retained, not dropped.
- FSM, two states:
  - IDLE, irq_valid=0: if cand != 0 and clear_all=0, irq_id <= index of the highest set bit of cand, irq_valid <= 1, go to PRESENT.
  - PRESENT, irq_valid=1: irq_id is held constant. On irq_ack=1, clear pending[irq_id], irq_valid <= 0, go to IDLE.
  - clear_all in PRESENT: irq_valid <= 0, go to IDLE; pending is zeroed.
- Grant rules:
  - Clearing a mask bit or raising a higher request while in PRESENT does not change the grant in progress.
  - irq_ack while irq_valid=0 is ignored.
- Latency:
  - req[i] first sampled high at edge E0 -> pending[i]=1 after E0 -> irq_valid=1 with irq_id=i after E1.
  - Ack at edge Ea -> irq_valid=0 after Ea -> next grant, if any, after Ea+1. There is one idle cycle minimum between grants.
- Level mode: an acked line that is still high sets its pending bit again in the same cycle (set wins) and is re-granted.
- pend_any is combinational from pending.

Test Plan:
- Reset, then req=8'h00, mask=8'hFF for 5 cycles -> irq_valid=0, pending=0, pend_any=0 throughout.
- req pulses 8'h24 for one cycle, mask=8'hFF -> pending=8'h24; grant irq_id=5; ack -> pending=8'h04; one idle cycle; grant irq_id=2; ack -> pending=0.
- mask=8'h7F, req[7] and req[1] pulse together -> irq_id=1 granted, pending[7] stays set; set mask=8'hFF after acking id 1 -> irq_id=7 granted.
- While presenting id=3, new rising edge on req[3] in the same cycle as irq_ack -> pending[3] remains 1, id=3 granted again after one idle cycle.
- EDGE_MODE=1, req[0] held high for 20 cycles with acks -> exactly one grant. EDGE_MODE=0, same stimulus -> a grant every 3 cycles while high.
- clear_all during PRESENT with pending=8'hF0 -> next cycle irq_valid=0, pending=0. rst asserted mid-grant -> all outputs 0 after the edge.
